// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if: the strobe/level inputs and the display/lap outputs of stopwatch_core.
// The master side (joystick decode, debouncers, tick generator and the display path) drives
// the inputs and reads the outputs. The slave side is the core.
interface stopwatch_core_if #(
    parameter int LAP_DEPTH = 4
);
    localparam int IW = $clog2(LAP_DEPTH);

    logic          tick_1hz;
    logic          adj_tick;
    logic          start_stop;
    logic          lap;
    logic          clear;
    logic          dir;
    logic          adj;
    logic          sel;
    logic [9:0]    jstk_y;
    logic [IW-1:0] lap_rd_idx;
    logic [3:0]    min_tens;
    logic [3:0]    min_ones;
    logic [3:0]    sec_tens;
    logic [3:0]    sec_ones;
    logic          running;
    logic          expired;
    logic [IW:0]   lap_count;
    logic [15:0]   lap_rd_data;

    modport master (
        output tick_1hz, adj_tick, start_stop, lap, clear, dir, adj, sel, jstk_y, lap_rd_idx,
        input  min_tens, min_ones, sec_tens, sec_ones, running, expired, lap_count, lap_rd_data
    );

    modport slave (
        input  tick_1hz, adj_tick, start_stop, lap, clear, dir, adj, sel, jstk_y, lap_rd_idx,
        output min_tens, min_ones, sec_tens, sec_ones, running, expired, lap_count, lap_rd_data
    );
endinterface

// File: rtl/stopwatch_core.sv
// stopwatch_core: registered BCD mm:ss up/down timer. It has IDLE/RUN/PAUSE/ADJUST/EXPIRED
// control and an optional circular lap buffer.
// Define STOPWATCH_LAP_EN to build the lap buffer. When the macro is undefined, lap is ignored,
// and lap_count and lap_rd_data read as zero.
// The time register holds {min_tens, min_ones, sec_tens, sec_ones}. BCD ordering matches numeric
// ordering, so plain comparisons on the packed value are valid.
module stopwatch_core #(
    parameter int MAX_MIN   = 99,
    parameter int LAP_DEPTH = 4,
    parameter int JSTK_HI   = 768,
    parameter int JSTK_LO   = 256
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_core_if.slave bus
);
    localparam int          IW       = $clog2(LAP_DEPTH);
    localparam logic [7:0]  MAX_BCD  = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [7:0]  SEC_TOP  = 8'h59;
    localparam logic [15:0] TOP_TIME = {MAX_BCD, SEC_TOP};
    localparam logic [9:0]  HI_LIM   = 10'(JSTK_HI);
    localparam logic [9:0]  LO_LIM   = 10'(JSTK_LO);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PAUSE   = 3'd2,
        S_ADJUST  = 3'd3,
        S_EXPIRED = 3'd4
    } state_t;

    state_t      state_r;
    logic [15:0] tm_r;
    logic        running_r;
    logic        expired_r;
    logic        tm_zero_s;
    logic        jstk_up_s;
    logic        jstk_dn_s;

    // Two-digit BCD increment that wraps from top back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        logic [7:0] r;
        if (v == top) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD decrement that wraps from 00 up to top.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = top;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // mm:ss plus one second. The caller guarantees the time is below TOP_TIME.
    function automatic logic [15:0] time_inc(input logic [15:0] t);
        logic [15:0] r;
        if (t[7:0] == SEC_TOP) begin
            r = {bcd_inc(t[15:8], MAX_BCD), 8'h00};
        end else begin
            r = {t[15:8], bcd_inc(t[7:0], SEC_TOP)};
        end
        return r;
    endfunction

    // mm:ss minus one second. The caller guarantees the time is above 00:01.
    function automatic logic [15:0] time_dec(input logic [15:0] t);
        logic [15:0] r;
        if (t[7:0] == 8'h00) begin
            r = {bcd_dec(t[15:8], MAX_BCD), SEC_TOP};
        end else begin
            r = {t[15:8], bcd_dec(t[7:0], SEC_TOP)};
        end
        return r;
    endfunction

    assign tm_zero_s = (tm_r == 16'h0000);
    assign jstk_up_s = (bus.jstk_y > HI_LIM);
    assign jstk_dn_s = (bus.jstk_y < LO_LIM);

    // Control FSM together with the time register and the registered running/expired flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            tm_r      <= 16'h0000;
            running_r <= 1'b0;
            expired_r <= 1'b0;
        end else if (bus.clear) begin
            state_r   <= S_IDLE;
            tm_r      <= 16'h0000;
            running_r <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_PAUSE: begin
                    // A down-count start from 00:00 has nothing to count, so it is ignored.
                    if (bus.start_stop && !(bus.dir && tm_zero_s)) begin
                        state_r   <= S_RUN;
                        running_r <= 1'b1;
                    end else if (bus.adj) begin
                        state_r <= S_ADJUST;
                    end
                end
                S_RUN: begin
                    // The pause pulse consumes the cycle, so a coincident tick is dropped.
                    if (bus.start_stop) begin
                        state_r   <= S_PAUSE;
                        running_r <= 1'b0;
                    end else if (bus.tick_1hz) begin
                        if (!bus.dir) begin
                            if (tm_r == TOP_TIME) begin
                                state_r   <= S_EXPIRED;
                                running_r <= 1'b0;
                                expired_r <= 1'b1;
                            end else begin
                                tm_r <= time_inc(tm_r);
                            end
                        end else if (tm_r <= 16'h0001) begin
                            tm_r      <= 16'h0000;
                            state_r   <= S_EXPIRED;
                            running_r <= 1'b0;
                            expired_r <= 1'b1;
                        end else begin
                            tm_r <= time_dec(tm_r);
                        end
                    end
                end
                S_ADJUST: begin
                    if (!bus.adj) begin
                        state_r <= S_PAUSE;
                    end else if (bus.adj_tick) begin
                        // Fields wrap on their own; seconds never carry into minutes here.
                        if (jstk_up_s) begin
                            if (bus.sel) begin
                                tm_r[15:8] <= bcd_inc(tm_r[15:8], MAX_BCD);
                            end else begin
                                tm_r[7:0] <= bcd_inc(tm_r[7:0], SEC_TOP);
                            end
                        end else if (jstk_dn_s) begin
                            if (bus.sel) begin
                                tm_r[15:8] <= bcd_dec(tm_r[15:8], MAX_BCD);
                            end else begin
                                tm_r[7:0] <= bcd_dec(tm_r[7:0], SEC_TOP);
                            end
                        end
                    end
                end
                S_EXPIRED: begin
                    if (bus.start_stop) begin
                        state_r   <= S_IDLE;
                        expired_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    running_r <= 1'b0;
                    expired_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.min_tens = tm_r[15:12];
    assign bus.min_ones = tm_r[11:8];
    assign bus.sec_tens = tm_r[7:4];
    assign bus.sec_ones = tm_r[3:0];
    assign bus.running  = running_r;
    assign bus.expired  = expired_r;

`ifdef STOPWATCH_LAP_EN
    localparam int          CW       = IW + 1;
    localparam logic [IW:0] LAP_FULL = CW'(LAP_DEPTH);

    logic [15:0]   lap_mem [LAP_DEPTH];
    logic [IW-1:0] wr_ptr_r;
    logic [IW:0]   lap_cnt_r;
    logic [15:0]   rd_data_r;
    logic          lap_we_s;
    logic [IW-1:0] rd_ptr_s;

    // A lap is captured only while RUN actually holds for the cycle. A pause pulse outranks it.
    assign lap_we_s = bus.lap && !bus.clear && !bus.start_stop && (state_r == S_RUN);
    // Index 0 is the newest entry, just behind the write pointer. The subtraction wraps modulo depth.
    assign rd_ptr_s = wr_ptr_r - IW'(1) - bus.lap_rd_idx;

    // Write pointer and saturating valid-entry count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            lap_cnt_r <= '0;
        end else if (bus.clear) begin
            wr_ptr_r  <= '0;
            lap_cnt_r <= '0;
        end else if (lap_we_s) begin
            wr_ptr_r <= wr_ptr_r + IW'(1);
            if (lap_cnt_r != LAP_FULL) begin
                lap_cnt_r <= lap_cnt_r + CW'(1);
            end
        end
    end

    // Lap storage records the pre-tick time. The entries need no reset because lap_cnt_r masks stale ones.
    always_ff @(posedge clk) begin
        if (lap_we_s) begin
            lap_mem[wr_ptr_r] <= tm_r;
        end
    end

    // Registered readback. Indices beyond the valid count read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= 16'h0000;
        end else if ({1'b0, bus.lap_rd_idx} < lap_cnt_r) begin
            rd_data_r <= lap_mem[rd_ptr_s];
        end else begin
            rd_data_r <= 16'h0000;
        end
    end

    assign bus.lap_count   = lap_cnt_r;
    assign bus.lap_rd_data = rd_data_r;
`else
    logic unused_lap_s;

    assign unused_lap_s    = ^{bus.lap, bus.lap_rd_idx};
    assign bus.lap_count   = {(IW + 1){1'b0}};
    assign bus.lap_rd_data = 16'h0000;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed and random stimulus for stopwatch_core. The expected outputs come
// from a seconds-and-queue reference model and are checked through a scoreboard queue.
module tb_stopwatch_core;
    localparam int MAX_MIN   = 99;
    localparam int LAP_DEPTH = 4;
    localparam int JSTK_HI   = 768;
    localparam int JSTK_LO   = 256;
    localparam int IW        = $clog2(LAP_DEPTH);
    localparam int TOP       = MAX_MIN * 60 + 59;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    stopwatch_core_if #(.LAP_DEPTH(LAP_DEPTH)) bus();

    stopwatch_core #(
        .MAX_MIN(MAX_MIN), .LAP_DEPTH(LAP_DEPTH), .JSTK_HI(JSTK_HI), .JSTK_LO(JSTK_LO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] tm;
        logic        running;
        logic        expired;
        logic [IW:0] cnt;
        logic [15:0] rd;
    } exp_t;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ADJ, M_EXP} mode_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    mode_t       m_mode;
    int          m_secs;
    logic [15:0] m_laps[$];

    function automatic logic [15:0] to_bcd(input int t);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] dut_time();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_secs = 0;
        m_laps.delete();
    endtask

    // Drive one cycle of inputs, advance the reference model, and queue the expected outputs.
    task automatic cycle(input bit ss, input bit lp, input bit clr, input bit tk, input bit at,
                         input bit d, input bit a, input bit s, input logic [9:0] jy,
                         input logic [IW-1:0] idx);
        exp_t e;
        int   mm;
        int   sc;
        int   stp;
        @(negedge clk);
        bus.start_stop = ss;  bus.lap = lp;  bus.clear = clr;  bus.tick_1hz = tk;
        bus.adj_tick = at;    bus.dir = d;   bus.adj = a;      bus.sel = s;
        bus.jstk_y = jy;      bus.lap_rd_idx = idx;
        e.rd = (LAP_EN && int'(idx) < m_laps.size()) ? m_laps[int'(idx)] : 16'h0000;
        if (clr) begin
            model_reset();
        end else begin
            case (m_mode)
                M_IDLE, M_PAUSE: begin
                    if (ss && !(d && m_secs == 0)) m_mode = M_RUN;
                    else if (a) m_mode = M_ADJ;
                end
                M_RUN: begin
                    if (ss) begin
                        m_mode = M_PAUSE;
                    end else begin
                        if (lp && LAP_EN) begin
                            m_laps.push_front(to_bcd(m_secs));
                            if (m_laps.size() > LAP_DEPTH) void'(m_laps.pop_back());
                        end
                        if (tk) begin
                            if (!d) begin
                                if (m_secs == TOP) m_mode = M_EXP;
                                else m_secs++;
                            end else if (m_secs <= 1) begin
                                m_secs = 0;
                                m_mode = M_EXP;
                            end else begin
                                m_secs--;
                            end
                        end
                    end
                end
                M_ADJ: begin
                    if (!a) begin
                        m_mode = M_PAUSE;
                    end else if (at && (jy > JSTK_HI || jy < JSTK_LO)) begin
                        stp = (jy > JSTK_HI) ? 1 : -1;
                        mm  = m_secs / 60;
                        sc  = m_secs % 60;
                        if (s) mm = (mm + stp + MAX_MIN + 1) % (MAX_MIN + 1);
                        else   sc = (sc + stp + 60) % 60;
                        m_secs = mm * 60 + sc;
                    end
                end
                M_EXP: begin
                    if (ss) m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
        e.tm      = to_bcd(m_secs);
        e.running = (m_mode == M_RUN);
        e.expired = (m_mode == M_EXP);
        e.cnt     = (IW + 1)'(m_laps.size());
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start_stop = 1'b0;  bus.lap = 1'b0;  bus.clear = 1'b0;
        bus.tick_1hz = 1'b0;    bus.adj_tick = 1'b0;
    endtask

    task automatic idle(input bit d, input logic [IW-1:0] idx);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d, 1'b0, 1'b0, 10'd512, idx);
    endtask

    task automatic tick(input bit d);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d, 1'b0, 1'b0, 10'd512, '0);
    endtask

    task automatic press(input bit d);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d, 1'b0, 1'b0, 10'd512, '0);
    endtask

    task automatic do_clear();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd512, '0);
    endtask

    task automatic adj_step(input bit s, input logic [9:0] jy);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, s, jy, '0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.adj = 1'b0;
        model_reset();
        #1;
        chk("rst_time", dut_time(), 16'h0000);
        chk("rst_running", 16'(bus.running), 16'h0000);
        chk("rst_expired", 16'(bus.expired), 16'h0000);
        chk("rst_lap_count", 16'(bus.lap_count), 16'h0000);
        chk("rst_lap_rd_data", bus.lap_rd_data, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: after each edge, pop the queued expectation and compare every output.
    always begin : monitor
        exp_t e;
        @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("time", dut_time(), e.tm);
            chk("running", 16'(bus.running), 16'(e.running));
            chk("expired", 16'(bus.expired), 16'(e.expired));
            chk("lap_count", 16'(bus.lap_count), 16'(e.cnt));
            chk("lap_rd_data", bus.lap_rd_data, e.rd);
        end
    end

    initial begin : stim
        logic [9:0] jv [8];
        bit         r_dir;
        bit         r_adj;
        bit         r_sel;
        jv = '{10'd100, 10'd255, 10'd256, 10'd512, 10'd768, 10'd769, 10'd900, 10'd0};
        bus.start_stop = 1'b0;  bus.lap = 1'b0;  bus.clear = 1'b0;  bus.tick_1hz = 1'b0;
        bus.adj_tick = 1'b0;    bus.dir = 1'b0;  bus.adj = 1'b0;    bus.sel = 1'b0;
        bus.jstk_y = 10'd512;   bus.lap_rd_idx = '0;
        rst = 1'b0;
        #2;
        apply_reset();

        // Count up 61 s, then pause and confirm the time holds.
        press(1'b0);
        for (int i = 0; i < 61; i++) tick(1'b0);
        chk("run61_time", dut_time(), 16'h0101);
        chk("run61_running", 16'(bus.running), 16'h0001);
        press(1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0);
        chk("pause_hold", dut_time(), 16'h0101);

        // A down-count start at 00:00 is ignored.
        do_clear();
        press(1'b1);
        chk("start_dn_zero", 16'(bus.running), 16'h0000);

        // Preset 00:02, count down to expiry, and check that a further tick changes nothing.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd512, '0);
        adj_step(1'b0, 10'd900);
        adj_step(1'b0, 10'd900);
        idle(1'b1, '0);
        press(1'b1);
        tick(1'b1);
        tick(1'b1);
        chk("dn_exp_time", dut_time(), 16'h0000);
        chk("dn_exp_flag", 16'(bus.expired), 16'h0001);
        chk("dn_exp_running", 16'(bus.running), 16'h0000);
        tick(1'b1);
        chk("dn_exp_hold", dut_time(), 16'h0000);
        press(1'b1);

        // Minute adjust wraps 99 -> 00. The seconds decrement wraps without a borrow.
        do_clear();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd512, '0);
        for (int i = 0; i < 100; i++) begin
            adj_step(1'b1, 10'd900);
            if (i == 98) chk("adj_min99", dut_time(), 16'h9900);
        end
        chk("adj_min_wrap", dut_time(), 16'h0000);
        adj_step(1'b0, 10'd100);
        chk("adj_sec_wrap", dut_time(), 16'h0059);
        adj_step(1'b1, 10'd100);
        chk("adj_min_dn", dut_time(), 16'h9959);
        idle(1'b0, '0);
        press(1'b0);
        tick(1'b0);
        chk("up_max_time", dut_time(), 16'h9959);
        chk("up_max_exp", 16'(bus.expired), 16'h0001);

        // Five laps at 00:01..00:05 into a four-entry buffer.
        do_clear();
        press(1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0);
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd512, '0);
        end
        chk("lap_count_sat", 16'(bus.lap_count), LAP_EN ? 16'd4 : 16'd0);
        idle(1'b0, 2'd0);
        chk("lap_idx0", bus.lap_rd_data, LAP_EN ? 16'h0005 : 16'h0000);
        idle(1'b0, 2'd3);
        chk("lap_idx3", bus.lap_rd_data, LAP_EN ? 16'h0002 : 16'h0000);
        for (int k = 0; k < 4; k++) tick(1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd512, '0);
        chk("lap_tick_time", dut_time(), 16'h0010);
        idle(1'b0, 2'd0);
        chk("lap_tick_entry", bus.lap_rd_data, LAP_EN ? 16'h0009 : 16'h0000);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd512, '0);
        chk("clr_ss_time", dut_time(), 16'h0000);
        chk("clr_ss_running", 16'(bus.running), 16'h0000);
        chk("clr_ss_count", 16'(bus.lap_count), 16'h0000);

        // Random traffic, with one asynchronous reset in the middle of it.
        r_dir = 1'b0;
        r_adj = 1'b0;
        r_sel = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) r_dir = ~r_dir;
            if ($urandom_range(29) == 0) r_adj = ~r_adj;
            if ($urandom_range(9) == 0)  r_sel = ~r_sel;
            cycle($urandom_range(19) == 0, $urandom_range(7) == 0, $urandom_range(299) == 0,
                  $urandom_range(1) == 0, $urandom_range(1) == 0, r_dir, r_adj, r_sel,
                  ($urandom_range(3) == 0) ? 10'($urandom_range(1023)) : jv[$urandom_range(7)],
                  IW'($urandom_range(LAP_DEPTH - 1)));
            if (i == 1500) begin
                #2;
                r_adj = 1'b0;
                apply_reset();
            end
        end

        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
